muldiv_seq_ctrl: RTL and testbench



---
 rtl/muldiv_seq_ctrl_pkg.sv | 26 ++
 rtl/muldiv_seq_ctrl_if.sv | 31 +++
 rtl/muldiv_seq_ctrl_addsub.sv | 30 +++
 rtl/muldiv_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared types and constants for the sequential RV32M unsigned multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL,
        OP_MULHU,
        OP_DIVU,
        OP_REMU
    } md_op_t;

    // Quotient returned for a zero divisor; sliced down to the datapath width by users.
    localparam logic [63:0] DIV0_ALL_ONES = '1;

    function automatic logic is_div(md_op_t op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates requests, res_ready holds the result in place.
// Ports: master = requester (EX stage), slave = muldiv_seq_ctrl.
interface muldiv_seq_ctrl_if #(
    parameter int N = 32
);
    import muldiv_pkg::*;

    logic         req_valid;
    logic         req_ready;
    md_op_t       op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         kill;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] result;
    logic         busy;

    modport master (
        output req_valid, op, a, b, kill, res_ready,
        input  req_ready, res_valid, result, busy
    );

    modport slave (
        input  req_valid, op, a, b, kill, res_ready,
        output req_ready, res_valid, result, busy
    );

endinterface

// File: rtl/muldiv_seq_ctrl_addsub.sv
// Ripple-carry adder/subtractor: cin=1 inverts y, giving x - y with cout = no-borrow.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y operands; cin carry-in / subtract select; sum result; cout carry out of the MSB.
module addsub_cout #(
    parameter int W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] y_eff;
    logic [W:0]   carry;

    always_comb begin
        y_eff    = y ^ {W{cin}};
        carry    = '0;
        carry[0] = cin;
        sum      = '0;
        for (int i = 0; i < W; i++) begin
            sum[i]       = x[i] ^ y_eff[i] ^ carry[i];
            carry[i+1]   = (x[i] & y_eff[i]) | (carry[i] & (x[i] ^ y_eff[i]));
        end
        cout = carry[W];
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequential MUL/MULHU/DIVU/REMU: shift-add multiply, restoring divide on one shared adder.
// Latency: N+1 edges from acceptance (acceptance edge + N iterations); divide-by-zero 1 edge.
// Backpressure: result held in DONE until res_ready; req_ready only in IDLE; kill aborts.
// Ports: clk, rst (async, active-high); bus = slave side of muldiv_seq_ctrl_if.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    muldiv_seq_ctrl_if.slave bus
);

    localparam logic [N-1:0]     DIV0_QUO = DIV0_ALL_ONES[N-1:0];
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state, state_nxt;
    md_op_t           op_q;
    logic [N-1:0]     b_q;
    // acc_q is hi (multiply) or rem (divide). A restored remainder is always < b,
    // so its top bit is never set and N bits suffice.
    logic [N-1:0]     acc_q;
    logic [N-1:0]     lo_q;     // lo (multiply) or quo (divide)
    logic [N-1:0]     res_q;
    logic [CNT_W-1:0] cnt_q;

    logic [N:0]       add_x, add_y, add_sum;
    logic             add_cin, add_cout;
    logic [N-1:0]     acc_step, lo_step, res_calc;
    logic             last_iter, div0;

    addsub_cout #(.W(N + 1)) u_addsub (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign last_iter = (cnt_q == CNT_LAST);
    assign div0      = is_div(bus.op) && (bus.b == '0);

    // Adder operand mux and one iteration's register update. Outside CALC the
    // adder sees zeros so it does not toggle.
    always_comb begin
        add_x    = '0;
        add_y    = '0;
        add_cin  = 1'b0;
        acc_step = acc_q;
        lo_step  = lo_q;
        if (state == CALC) begin
            if (is_div(op_q)) begin
                // Trial subtract of b from the remainder shifted left by one quotient bit.
                add_x    = {acc_q, lo_q[N-1]};
                add_y    = {1'b0, b_q};
                add_cin  = 1'b1;
                acc_step = add_cout ? add_sum[N-1:0] : add_x[N-1:0];
                lo_step  = {lo_q[N-2:0], add_cout};
            end else begin
                // Adding zero when the multiplier bit is clear keeps one adder path.
                add_x    = {1'b0, acc_q};
                add_y    = lo_q[0] ? {1'b0, b_q} : '0;
                acc_step = add_sum[N:1];
                lo_step  = {add_sum[0], lo_q[N-1:1]};
            end
        end
        case (op_q)
            OP_MUL:   res_calc = lo_step;
            OP_MULHU: res_calc = acc_step;
            OP_DIVU:  res_calc = lo_step;
            default:  res_calc = acc_step;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = (state == IDLE);
        bus.res_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.result    = res_q;
        case (state)
            IDLE: if (bus.req_valid) state_nxt = div0 ? DONE : CALC;
            CALC: if (last_iter)     state_nxt = DONE;
            DONE: if (bus.res_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
        if (bus.kill) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_MUL;
            b_q   <= '0;
            acc_q <= '0;
            lo_q  <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else if (!bus.kill) begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.op;
                        b_q   <= bus.b;
                        acc_q <= '0;
                        lo_q  <= bus.a;
                        cnt_q <= '0;
                        if (div0) begin
                            res_q <= (bus.op == OP_DIVU) ? DIV0_QUO : bus.a;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        res_q <= res_calc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: directed vectors plus a per-cycle reference model.
// Latency: n/a.
// Backpressure: exercises held results, kill and asynchronous reset mid-operation.
module tb_muldiv_seq_ctrl;
    import muldiv_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_seq_ctrl_if #(.N(N)) bus();

    muldiv_seq_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: architectural result by plain arithmetic, timing as a
    // count of edges since acceptance.
    bit           m_busy, m_done;
    int           m_cnt, m_lat;
    logic [N-1:0] m_res;

    function automatic logic [N-1:0] ref_result(md_op_t op, logic [N-1:0] a, logic [N-1:0] b);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        case (op)
            OP_MUL:   return p[N-1:0];
            OP_MULHU: return p[2*N-1:N];
            OP_DIVU:  return (b == 0) ? {N{1'b1}} : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_cnt = 0; m_lat = 0; m_res = '0;
        end else if (bus.kill) begin
            m_busy = 0; m_done = 0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy = 1;
                m_cnt  = 1;
                m_lat  = ((bus.op == OP_DIVU || bus.op == OP_REMU) && bus.b == 0) ? 1 : N + 1;
                m_res  = ref_result(bus.op, bus.a, bus.b);
                m_done = (m_lat == 1);
            end
        end else if (!m_done) begin
            m_cnt++;
            m_done = (m_cnt == m_lat);
        end else if (bus.res_ready) begin
            m_busy = 0; m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk1("rst_req_ready", bus.req_ready, 1'b1);
            chk1("rst_res_valid", bus.res_valid, 1'b0);
            chk1("rst_busy", bus.busy, 1'b0);
            chk("rst_result", bus.result, '0);
        end else begin
            chk1("req_ready", bus.req_ready, !m_busy);
            chk1("busy", bus.busy, m_busy);
            chk1("res_valid", bus.res_valid, m_done);
            if (m_done) chk("result", bus.result, m_res);
        end
    end

    // Called just after a negedge with the DUT idle; returns just after a negedge
    // with the DUT idle again so calls chain back-to-back.
    task automatic run_op(input md_op_t op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp, input int exp_lat, input int hold,
                          input string name);
        int           edges;
        logic [N-1:0] held;
        bus.req_valid = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.res_ready = 1'b0;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.a  = N'($urandom);
        bus.b  = N'($urandom);
        bus.op = md_op_t'($urandom_range(0, 3));
        while (!bus.res_valid && edges < N + 10) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk_int({name, "_lat"}, edges, exp_lat);
        chk({name, "_res"}, bus.result, exp);
        held = bus.result;
        repeat (hold) begin
            @(negedge clk);
            chk({name, "_hold"}, bus.result, held);
            chk1({name, "_hold_req_ready"}, bus.req_ready, 1'b0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk1({name, "_idle"}, bus.req_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.op        = OP_MUL;
        bus.a         = '0;
        bus.b         = '0;
        bus.kill      = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(OP_MUL,   32'd7,        32'd6,        32'd42,       N + 1, 10, "mul_7x6");
        run_op(OP_MULHU, 32'd7,        32'd6,        32'd0,        N + 1, 0,  "mulhu_7x6");
        run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, N + 1, 0,  "mulhu_max");
        run_op(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, N + 1, 0,  "mul_max");
        run_op(OP_DIVU,  32'd100,      32'd7,        32'd14,       N + 1, 0,  "divu_100_7");
        run_op(OP_REMU,  32'd100,      32'd7,        32'd2,        N + 1, 0,  "remu_100_7");
        run_op(OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, N + 1, 0,  "divu_max_1");
        run_op(OP_REMU,  32'd5,        32'd9,        32'd5,        N + 1, 2,  "remu_5_9");
        run_op(OP_DIVU,  32'd123,      32'd0,        32'hFFFFFFFF, 1,     3,  "divu_by0");
        run_op(OP_REMU,  32'd123,      32'd0,        32'd123,      1,     0,  "remu_by0");

        // kill partway through CALC
        bus.req_valid = 1'b1; bus.op = OP_MUL; bus.a = 32'd1234; bus.b = 32'd5678;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        chk1("kill_req_ready", bus.req_ready, 1'b1);
        chk1("kill_busy", bus.busy, 1'b0);
        seen = 0;
        repeat (N + 5) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1;
        end
        chk1("kill_no_result", seen, 1'b0);

        // kill in IDLE blocks a simultaneous request
        bus.kill = 1'b1; bus.req_valid = 1'b1; bus.op = OP_DIVU; bus.a = 32'd9; bus.b = 32'd0;
        @(negedge clk);
        bus.kill = 1'b0; bus.req_valid = 1'b0;
        chk1("kill_idle_busy", bus.busy, 1'b0);
        chk1("kill_idle_res_valid", bus.res_valid, 1'b0);
        @(negedge clk);

        // asynchronous reset mid-CALC
        bus.req_valid = 1'b1; bus.op = OP_DIVU; bus.a = 32'd999; bus.b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("arst_req_ready", bus.req_ready, 1'b1);
        chk1("arst_res_valid", bus.res_valid, 1'b0);
        chk1("arst_busy", bus.busy, 1'b0);
        chk("arst_result", bus.result, '0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (N + 5) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1;
        end
        chk1("arst_no_result", seen, 1'b0);

        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, N + 1, 0, "post_rst_divu");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
